// File: rtl/perm_sr_bank.sv
// perm_sr_bank: keyed-lock bank of set/reset permission bits with conflict resolution;
// optional per-bit lease expiry when PERM_LEASE_EN is defined.
module perm_sr_bank #(
  parameter int WIDTH = 8,
  parameter int CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int KEY_W = 16,
  parameter logic [KEY_W-1:0] UNLOCK_KEY = 'hA5C3,
  parameter int MAX_FAILS = 3,
  parameter int LEASE_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  input  logic lock,
  input  logic unlock,
  input  logic [KEY_W-1:0] key,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] changed,
  output logic conflict,
  output logic locked,
  output logic frozen,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic [WIDTH-1:0] expired
);
  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] LOCKED = 2'd1;
  localparam logic [1:0] FROZEN = 2'd2;
  localparam int FW = $clog2(MAX_FAILS+1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAILS);
  logic [1:0] state, state_nxt;
  logic [FW-1:0] fc_nxt;
  logic acc;
  logic [WIDTH-1:0] cm, res, nxt;
  assign acc = state == UNLOCKED;
  assign locked = state == LOCKED;
  assign frozen = state == FROZEN;
  assign cm = CONFLICT_MODE == 1 ? '1 : CONFLICT_MODE == 2 ? '0 : CONFLICT_MODE == 3 ? ~out : out;
  assign res = acc ? (set & reset & cm) | (set & ~reset) | (~(set | reset) & out) : out;
  // lock wins over unlock in the same cycle, in either unlocked or locked state
  always_comb begin
    state_nxt = state;
    fc_nxt = fail_count;
    if (state == UNLOCKED && lock) state_nxt = LOCKED;
    else if (state == LOCKED && unlock && !lock) begin
      if (key == UNLOCK_KEY) begin
        state_nxt = UNLOCKED;
        fc_nxt = '0;
      end else begin
        fc_nxt = fail_count + 1'b1;
        state_nxt = fc_nxt == FMAX ? FROZEN : LOCKED;
      end
    end
  end
`ifdef PERM_LEASE_EN
  localparam int CW = $clog2(LEASE_CYCLES+1);
  logic [CW-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] load, exp_c;
  assign load = {WIDTH{acc}} & set & res;
  // a zero counter on a set bit means no lease is running (e.g. a RESET_VAL bit)
  always_comb begin
    exp_c = '0;
    for (int i = 0; i < WIDTH; i++) exp_c[i] = out[i] && cnt[i] == CW'(1) && !load[i];
  end
  assign nxt = res & ~exp_c;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      expired <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      expired <= exp_c;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= load[i] ? CW'(LEASE_CYCLES) : (nxt[i] && cnt[i] != '0) ? cnt[i] - 1'b1 : '0;
    end
`else
  assign nxt = res;
  assign expired = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= RESET_VAL;
      changed <= '0;
      conflict <= 1'b0;
      state <= UNLOCKED;
      fail_count <= '0;
    end else begin
      out <= nxt;
      changed <= nxt ^ out;
      conflict <= acc && |(set & reset);
      state <= state_nxt;
      fail_count <= fc_nxt;
    end
endmodule

// File: tb/tb_perm_sr_bank.sv
// tb_perm_sr_bank: scoreboard bench, four conflict-mode instances plus a short-lease instance.
module tb_perm_sr_bank;
`ifdef PERM_LEASE_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] set = '0, reset = '0, ls = '0;
  logic lock = 1'b0, unlock = 1'b0, llk = 1'b0;
  logic [15:0] key = '0;
  logic [7:0] out [4], changed [4], expired [4];
  logic conflict [4], locked [4], frozen [4];
  logic [1:0] fc [4];
  logic [7:0] lout, lchg, lex;
  logic lcf, llocked, lfz;
  logic [1:0] lfc;
  int n_vec = 0, n_err = 0;
  for (genvar m = 0; m < 4; m++) begin : g_dut
    perm_sr_bank #(.CONFLICT_MODE(m), .RESET_VAL(8'h0F)) dut (
      .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .lock(lock), .unlock(unlock),
      .key(key), .out(out[m]), .changed(changed[m]), .conflict(conflict[m]),
      .locked(locked[m]), .frozen(frozen[m]), .fail_count(fc[m]), .expired(expired[m]));
  end
  perm_sr_bank #(.LEASE_CYCLES(4)) dl (
    .clk(clk), .rst_n(rst_n), .set(ls), .reset(8'h00), .lock(llk), .unlock(1'b0),
    .key(16'h0000), .out(lout), .changed(lchg), .conflict(lcf), .locked(llocked),
    .frozen(lfz), .fail_count(lfc), .expired(lex));
  typedef struct packed {
    logic [3:0][7:0] o;
    logic cf, lk, fz;
    logic [1:0] fc;
  } exp_t;
  typedef struct packed {
    logic [7:0] o, ex;
    logic lk;
  } lexp_t;
  exp_t q[$];
  lexp_t lq[$];
  logic [3:0][7:0] prev = {4{8'h0F}};
  logic [7:0] lprev = 8'h00;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int m = 0; m < 4; m++) begin
        n_vec += 7;
        if (out[m] !== e.o[m]) begin n_err++; $display("FAIL out m%0d: got %h want %h", m, out[m], e.o[m]); end
        if (changed[m] !== (e.o[m] ^ prev[m])) begin n_err++; $display("FAIL changed m%0d: got %h want %h", m, changed[m], e.o[m] ^ prev[m]); end
        if (conflict[m] !== e.cf) begin n_err++; $display("FAIL conflict m%0d: got %b want %b", m, conflict[m], e.cf); end
        if (locked[m] !== e.lk) begin n_err++; $display("FAIL locked m%0d: got %b want %b", m, locked[m], e.lk); end
        if (frozen[m] !== e.fz) begin n_err++; $display("FAIL frozen m%0d: got %b want %b", m, frozen[m], e.fz); end
        if (fc[m] !== e.fc) begin n_err++; $display("FAIL fail_count m%0d: got %0d want %0d", m, fc[m], e.fc); end
        if (expired[m] !== 8'h00) begin n_err++; $display("FAIL expired m%0d: got %h want 00", m, expired[m]); end
      end
      prev = e.o;
    end
  end
  always @(posedge clk) begin
    lexp_t e;
    #1;
    if (lq.size() != 0) begin
      e = lq.pop_front();
      n_vec += 4;
      if (lout !== e.o) begin n_err++; $display("FAIL lease out: got %h want %h", lout, e.o); end
      if (lchg !== (e.o ^ lprev)) begin n_err++; $display("FAIL lease changed: got %h want %h", lchg, e.o ^ lprev); end
      if (lex !== e.ex) begin n_err++; $display("FAIL lease expired: got %h want %h", lex, e.ex); end
      if (llocked !== e.lk) begin n_err++; $display("FAIL lease locked: got %b want %b", llocked, e.lk); end
      lprev = e.o;
    end
  end
  task automatic step(input logic [7:0] s, r, input logic lk, ul, input logic [15:0] k,
                      input logic [3:0][7:0] eo, input logic ecf, elk, efz, input logic [1:0] efc);
    exp_t e;
    @(negedge clk);
    set = s; reset = r; lock = lk; unlock = ul; key = k;
    e.o = eo; e.cf = ecf; e.lk = elk; e.fz = efz; e.fc = efc;
    q.push_back(e);
  endtask
  task automatic lstep(input logic [7:0] s, input logic lk, input logic [7:0] eo, eex, input logic elk);
    lexp_t e;
    @(negedge clk);
    ls = s; llk = lk;
    e.o = eo; e.ex = eex; e.lk = elk;
    lq.push_back(e);
  endtask
  task automatic check_reset_state(input string tag);
    for (int m = 0; m < 4; m++) begin
      n_vec += 6;
      if (out[m] !== 8'h0F) begin n_err++; $display("FAIL %s out m%0d: got %h want 0f", tag, m, out[m]); end
      if (changed[m] !== 8'h00 || conflict[m] !== 1'b0) begin n_err++; $display("FAIL %s pulses m%0d: got %h/%b want 00/0", tag, m, changed[m], conflict[m]); end
      if (locked[m] !== 1'b0) begin n_err++; $display("FAIL %s locked m%0d: got %b want 0", tag, m, locked[m]); end
      if (frozen[m] !== 1'b0) begin n_err++; $display("FAIL %s frozen m%0d: got %b want 0", tag, m, frozen[m]); end
      if (fc[m] !== 2'd0) begin n_err++; $display("FAIL %s fail_count m%0d: got %0d want 0", tag, m, fc[m]); end
      if (expired[m] !== 8'h00) begin n_err++; $display("FAIL %s expired m%0d: got %h want 00", tag, m, expired[m]); end
    end
  endtask
  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    n_vec++;
    if (lout !== 8'h00) begin n_err++; $display("FAIL reset lease out: got %h want 00", lout); end
    @(negedge clk) rst_n = 1'b1;
    prev = {4{8'h0F}};
  endtask
  task automatic test_set;
    step(8'h30, 8'h00, 0, 0, 16'h0, {4{8'h3F}}, 0, 0, 0, 0);
    step(8'h00, 8'h00, 0, 0, 16'h0, {4{8'h3F}}, 0, 0, 0, 0);
  endtask
  task automatic test_conflict;
    step(8'h00, 8'hFF, 0, 0, 16'h0, {4{8'h00}}, 0, 0, 0, 0);
    step(8'h01, 8'h00, 0, 0, 16'h0, {4{8'h01}}, 0, 0, 0, 0);
    step(8'h03, 8'h03, 0, 0, 16'h0, {8'h02, 8'h00, 8'h03, 8'h01}, 1, 0, 0, 0);
    step(8'h00, 8'h00, 0, 0, 16'h0, {8'h02, 8'h00, 8'h03, 8'h01}, 0, 0, 0, 0);
    step(8'h00, 8'hFF, 0, 0, 16'h0, {4{8'h00}}, 0, 0, 0, 0);
  endtask
  task automatic test_lock;
    step(8'h80, 8'h00, 1, 0, 16'h0, {4{8'h80}}, 0, 1, 0, 0);
    step(8'h00, 8'hFF, 0, 0, 16'h0, {4{8'h80}}, 0, 1, 0, 0);
    step(8'h03, 8'h03, 0, 0, 16'h0, {4{8'h80}}, 0, 1, 0, 0);
    step(8'h01, 8'h00, 0, 1, 16'hA5C3, {4{8'h80}}, 0, 0, 0, 0);
    step(8'h00, 8'h00, 0, 1, 16'h0000, {4{8'h80}}, 0, 0, 0, 0);
    step(8'h00, 8'h00, 1, 1, 16'hA5C3, {4{8'h80}}, 0, 1, 0, 0);
  endtask
  task automatic test_freeze;
    step(8'h00, 8'h00, 0, 1, 16'h0000, {4{8'h80}}, 0, 1, 0, 1);
    step(8'h00, 8'h00, 0, 1, 16'h0000, {4{8'h80}}, 0, 1, 0, 2);
    step(8'h00, 8'h00, 0, 1, 16'h0000, {4{8'h80}}, 0, 0, 1, 3);
    step(8'h00, 8'h00, 0, 1, 16'hA5C3, {4{8'h80}}, 0, 0, 1, 3);
    step(8'hFF, 8'h00, 0, 0, 16'h0, {4{8'h80}}, 0, 0, 1, 3);
    step(8'h03, 8'h03, 1, 0, 16'h0, {4{8'h80}}, 0, 0, 1, 3);
    step(8'h00, 8'h00, 0, 0, 16'h0, {4{8'h80}}, 0, 0, 1, 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    @(negedge clk) rst_n = 1'b1;
    prev = {4{8'h0F}};
  endtask
  task automatic test_back_to_back;
    step(8'hF0, 8'h00, 0, 0, 16'h0, {4{8'hFF}}, 0, 0, 0, 0);
    step(8'h00, 8'h0F, 0, 0, 16'h0, {4{8'hF0}}, 0, 0, 0, 0);
    step(8'h0F, 8'hF0, 0, 0, 16'h0, {4{8'h0F}}, 0, 0, 0, 0);
    step(8'h00, 8'h00, 0, 0, 16'h0, {4{8'h0F}}, 0, 0, 0, 0);
  endtask
  task automatic test_lease;
    lstep(8'h01, 0, 8'h01, 8'h00, 0);
    repeat (3) lstep(8'h00, 0, 8'h01, 8'h00, 0);
    lstep(8'h00, 0, LE ? 8'h00 : 8'h01, LE ? 8'h01 : 8'h00, 0);
    lstep(8'h00, 0, LE ? 8'h00 : 8'h01, 8'h00, 0);
    lstep(8'h01, 0, 8'h01, 8'h00, 0);
    lstep(8'h00, 0, 8'h01, 8'h00, 0);
    lstep(8'h01, 0, 8'h01, 8'h00, 0);
    repeat (3) lstep(8'h00, 0, 8'h01, 8'h00, 0);
    lstep(8'h00, 0, LE ? 8'h00 : 8'h01, LE ? 8'h01 : 8'h00, 0);
    lstep(8'h02, 1, LE ? 8'h02 : 8'h03, 8'h00, 1);
    repeat (3) lstep(8'h00, 0, LE ? 8'h02 : 8'h03, 8'h00, 1);
    lstep(8'h00, 0, LE ? 8'h00 : 8'h03, LE ? 8'h02 : 8'h00, 1);
    lstep(8'h00, 0, LE ? 8'h00 : 8'h03, 8'h00, 1);
  endtask
  initial begin
    test_reset();
    test_set();
    test_conflict();
    test_lock();
    test_freeze();
    test_back_to_back();
    test_lease();
    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0 || lq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q.size(), lq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/perm_sr_bank.md
Name: perm_sr_bank

Overview:
Parametrised bank of WIDTH set/reset permission bits. It is the successor to the single-bit SR flip-flop used in the permission read path. It adds deterministic set/reset conflict resolution, per-bit change reporting, and a keyed lock FSM that blocks permission updates while locked. Repeated bad unlock keys freeze the bank until reset. It sits between the permission-control logic and the protected-read gating, and its out bus drives read enables directly.

Parameters:
WIDTH, 8, number of permission bits/channels
CONFLICT_MODE, 0, set&reset same bit same cycle: 0=hold, 1=set-dominant, 2=reset-dominant, 3=toggle
RESET_VAL, {WIDTH{1'b0}}, value loaded into out on reset
KEY_W, 16, unlock key width
UNLOCK_KEY, 16'hA5C3, key that unlocks the bank
MAX_FAILS, 3, bad unlock attempts before FROZEN (>=1)
LEASE_CYCLES, 255, lease length in cycles (used only with PERM_LEASE_EN, >=1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
set  input  WIDTH  per-bit set request
reset  input  WIDTH  per-bit clear request
lock  input  1  lock request (level sampled per cycle)
unlock  input  1  unlock request, qualified by key
key  input  KEY_W  key presented with unlock
out  output  WIDTH  registered permission bits
changed  output  WIDTH  one-cycle pulse, bits of out that changed at the last edge
conflict  output  1  one-cycle pulse, an accepted update had set&reset on some bit
locked  output  1  FSM in LOCKED
frozen  output  1  FSM in FROZEN
fail_count  output  $clog2(MAX_FAILS+1)  bad unlock attempts since last good unlock/reset
expired  output  WIDTH  one-cycle pulse, lease expiry per bit (tied 0 without PERM_LEASE_EN)

Behaviour:
- Reset (async assert, sync release, clock-independent): out=RESET_VAL, changed=0, conflict=0, expired=0, FSM=UNLOCKED, fail_count=0, lease counters=0.
- Clocking: one-cycle latency. Inputs sampled at edge N appear on out, changed and conflict after edge N. All outputs are registered.
- Per-bit update when UNLOCKED: 00 hold; 01 clear; 10 set; 11 resolved by CONFLICT_MODE. No X is ever produced.
- The conflict pulse fires only for updates that are accepted. In LOCKED/FROZEN, set/reset are ignored entirely: no conflict, no changed.
- changed = out_next ^ out. Each is a single pulse even if several causes coincide.
- FSM states UNLOCKED, LOCKED, FROZEN:
  - UNLOCKED + lock: go to LOCKED. Set/reset in that same cycle are still applied, because acceptance uses the current state. lock beats unlock in the same cycle.
  - LOCKED + unlock + key==UNLOCK_KEY: go to UNLOCKED, fail_count=0. Set/reset in that cycle are ignored.
  - LOCKED + unlock + wrong key: fail_count+1. When it reaches MAX_FAILS, go to FROZEN.
  - LOCKED + lock: no effect.
  - UNLOCKED + unlock: no effect, fail_count unchanged.
  - FROZEN: absorbing. Only rst_n exits. out is held. fail_count saturates at MAX_FAILS.
- Reset mid-operation: all state returns immediately to reset values, including mid-lease and FROZEN.

Optional Feature:
PERM_LEASE_EN
- Defined:
  - Each bit has a counter of width $clog2(LEASE_CYCLES+1).
  - An accepted set that results in out bit=1 loads LEASE_CYCLES. This includes re-setting a bit already at 1.
  - While the bit is 1, the counter decrements each cycle. On the cycle it would reach 0, the bit clears and expired and changed pulse for that bit.
  - Leases run in all FSM states, so expiry is a revocation and is allowed while locked.
  - An accepted clear or toggle-to-0 zeroes the counter with no expired pulse.
  - Expiry coincident with an accepted set on the same bit: set wins, counter reloads, no expired pulse.
  - Expiry coincident with an accepted clear: bit 0, one changed pulse, expired pulse asserted.
- Undefined: no counters, expired tied 0, bits persist until explicitly cleared.

Test Plan:
- Reset with RESET_VAL=8'h0F, then set=8'h30 for 1 cycle -> out=8'h3F one edge later, changed=8'h30 for one cycle, conflict=0.
- CONFLICT_MODE=0..3, out=8'h01, set=reset=8'h03 for 1 cycle -> out = 8'h01 / 8'h03 / 8'h00 / 8'h02 respectively, conflict=1 for one cycle.
- lock with set=8'h80 same cycle -> out[7]=1, locked=1. Then reset=8'hFF -> out unchanged, changed=0. Then unlock with key=16'hA5C3 -> locked=0, fail_count=0.
- LOCKED, three unlocks with key=16'h0000 -> fail_count 1,2,3, frozen=1 after the third. Then unlock with the correct key, or set/reset -> no effect. rst_n=0 mid-cycle -> out=RESET_VAL immediately, frozen=0.
- PERM_LEASE_EN, LEASE_CYCLES=4: set bit0 once -> bit0 clears 4 cycles later with expired[0]=1 and changed[0]=1. Re-set on cycle 3 -> expiry delayed to 4 cycles after the re-set.
- PERM_LEASE_EN, lease expiring while LOCKED -> bit clears and expired pulses, locked remains 1.
